// File: rtl/seg7_capture_decoder_if.sv
// Bus between a multiplexed active-low 7-segment display path and the capture decoder.
// The display side (master) drives segments/selects; the decoder (slave) returns the decoded word.
interface seg7_capture_decoder_if #(
  parameter int NUM_DIGITS = 2
);
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   dig_n;
  logic [4*NUM_DIGITS-1:0] data_out;
  logic                    data_valid;
  logic                    err;
  logic [NUM_DIGITS-1:0]   digit_err;

  modport master (
    output seg_n,
    output dig_n,
    input  data_out,
    input  data_valid,
    input  err,
    input  digit_err
  );

  modport slave (
    input  seg_n,
    input  dig_n,
    output data_out,
    output data_valid,
    output err,
    output digit_err
  );
endinterface

// File: rtl/seg7_capture_decoder.sv
// Snoops a multiplexed active-low 7-segment bus, debounces each digit, decodes it back to a hex
// nibble and publishes the assembled word once every digit of a scan frame has been captured.
//
// state   | meaning
// IDLE    | no digit of the current frame captured yet
// COLLECT | some, not all, digits captured
// PUBLISH | one cycle: outputs carry the completed frame, seen mask cleared
module seg7_capture_decoder #(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  seg7_capture_decoder_if.slave bus
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 2);
  localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  state_t state, nextState;

  logic [SW-1:0] syncMeta, syncS, prevS;
  logic [CW-1:0] stableCnt;
  logic          captureEvt;

  logic [NUM_DIGITS-1:0]   digSel;
  logic [6:0]              segPat;
  logic                    digOneHot;
  logic                    capQual;
  logic [4:0]              decoded;

  logic [4*NUM_DIGITS-1:0] shadow, shadowNext;
  logic [NUM_DIGITS-1:0]   shadowErr, shadowErrNext;
  logic [NUM_DIGITS-1:0]   seen, seenNext;

  logic [4*NUM_DIGITS-1:0] dataOut;
  logic [NUM_DIGITS-1:0]   digitErr;
  logic                    errOut;

  // Returns {invalid, nibble}; unknown patterns decode to nibble 0 with the invalid flag set.
  function automatic logic [4:0] decodeSeg(input logic [6:0] p);
    case (p)
      7'h3F:   return 5'h00;
      7'h06:   return 5'h01;
      7'h5B:   return 5'h02;
      7'h4F:   return 5'h03;
      7'h66:   return 5'h04;
      7'h6D:   return 5'h05;
      7'h7D:   return 5'h06;
      7'h07:   return 5'h07;
      7'h7F:   return 5'h08;
      7'h6F:   return 5'h09;
      7'h77:   return 5'h0A;
      7'h7C:   return 5'h0B;
      7'h39:   return 5'h0C;
      7'h5E:   return 5'h0D;
      7'h79:   return 5'h0E;
      7'h71:   return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta  <= '1;
      syncS     <= '1;
      prevS     <= '1;
      stableCnt <= '0;
    end else begin
      syncMeta <= {bus.dig_n, bus.seg_n};
      syncS    <= syncMeta;
      prevS    <= syncS;
      if (syncS != prevS) begin
        stableCnt <= '0;
      end else if (stableCnt != CNT_SAT) begin
        stableCnt <= stableCnt + 1'b1;
      end
    end
  end

  // Saturating one past the fire value makes the capture a single pulse per stable episode.
  assign captureEvt = (syncS == prevS) && (stableCnt == CNT_FIRE);

  assign digSel    = ~syncS[SW-1:7];
  assign segPat    = ~syncS[6:0];
  assign digOneHot = (digSel != '0) && ((digSel & (digSel - 1'b1)) == '0);
  assign capQual   = captureEvt && digOneHot;
  assign decoded   = decodeSeg(segPat);

  always_comb begin
    shadowNext    = shadow;
    shadowErrNext = shadowErr;
    // Clearing seen in PUBLISH before merging lets a capture in that cycle start the next frame.
    seenNext      = (state == PUBLISH) ? '0 : seen;
    if (capQual) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digSel[i]) begin
          shadowNext[4*i +: 4] = decoded[3:0];
          shadowErrNext[i]     = decoded[4];
          seenNext[i]          = 1'b1;
        end
      end
    end
  end

  always_comb begin
    nextState = state;
    if (&seenNext) begin
      nextState = PUBLISH;
    end else if (|seenNext) begin
      nextState = COLLECT;
    end else begin
      nextState = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      shadowErr <= '0;
      seen      <= '0;
    end else begin
      state     <= nextState;
      shadow    <= shadowNext;
      shadowErr <= shadowErrNext;
      seen      <= seenNext;
    end
  end

  // Outputs load on entry to PUBLISH so they are already valid while data_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataOut  <= '0;
      digitErr <= '0;
      errOut   <= 1'b0;
    end else if (nextState == PUBLISH) begin
      dataOut  <= shadowNext;
      digitErr <= shadowErrNext;
      errOut   <= |shadowErrNext;
    end
  end

  assign bus.data_out   = dataOut;
  assign bus.digit_err  = digitErr;
  assign bus.err        = errOut;
  assign bus.data_valid = (state == PUBLISH);

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Scoreboard bench for seg7_capture_decoder: directed digit sequences push expected frames,
// a negedge monitor pops and compares whenever data_valid is seen.
module tb_seg7_capture_decoder;
  localparam int ND = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_capture_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg7_capture_decoder #(
    .NUM_DIGITS(ND),
    .STABLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] derr;
    logic       err;
    int         expCyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic drive(input logic [1:0] dig, input logic [6:0] pat, input int n);
    bus.dig_n  = dig;
    bus.seg_n  = ~pat;
    repeat (n) @(negedge clk);
  endtask

  // Final digit is driven right after this call: valid expected 8 edges later (2 sync + 4 + 1 + 1 sample edge).
  task automatic expectFrame(input logic [7:0] data, input logic [1:0] derr, input logic err);
    exp_t e;
    e.data   = data;
    e.derr   = derr;
    e.err    = err;
    e.expCyc = cyc + 8;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.data_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {31'd0, bus.data_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data_out", {24'd0, bus.data_out}, {24'd0, e.data});
        check("digit_err", {30'd0, bus.digit_err}, {30'd0, e.derr});
        check("err", {31'd0, bus.err}, {31'd0, e.err});
        check("latency", cyc, e.expCyc);
      end
    end
  end

  initial begin
    bus.dig_n = '1;
    bus.seg_n = '1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    check("rst_valid", {31'd0, bus.data_valid}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_digit_err", {30'd0, bus.digit_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame: digit0 '2', digit1 'A'
    drive(2'b10, 7'h5B, 8);
    expectFrame(8'hA2, 2'b00, 1'b0);
    drive(2'b01, 7'h77, 8);
    drive(2'b11, 7'h00, 4);

    // Glitch: pattern changes every 2 cycles, never captured
    for (int k = 0; k < 10; k++) begin
      drive(2'b10, (k % 2 == 1) ? 7'h4F : 7'h5B, 2);
    end
    drive(2'b11, 7'h00, 6);

    // Multi-select and blank held long: ignored
    drive(2'b00, 7'h3F, 20);
    drive(2'b11, 7'h3F, 20);

    // If anything above set seen[0], this frame would publish early with wrong data
    drive(2'b01, 7'h6D, 8);
    expectFrame(8'h59, 2'b00, 1'b0);
    drive(2'b10, 7'h6F, 8);
    drive(2'b11, 7'h00, 4);

    // Reset mid-frame with seen=01
    drive(2'b10, 7'h39, 8);
    drive(2'b11, 7'h00, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_data_out", {24'd0, bus.data_out}, 32'd0);
    check("midrst_valid", {31'd0, bus.data_valid}, 32'd0);
    check("midrst_err", {31'd0, bus.err}, 32'd0);
    check("midrst_digit_err", {30'd0, bus.digit_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    drive(2'b01, 7'h06, 8);
    drive(2'b11, 7'h00, 20);
    expectFrame(8'h10, 2'b00, 1'b0);
    drive(2'b10, 7'h3F, 8);
    drive(2'b11, 7'h00, 4);

    // Invalid pattern on digit0
    drive(2'b10, 7'h00, 8);
    expectFrame(8'h10, 2'b01, 1'b1);
    drive(2'b01, 7'h06, 8);
    drive(2'b11, 7'h00, 4);

    // Overwrite digit0 before frame completes
    drive(2'b10, 7'h4F, 8);
    drive(2'b10, 7'h07, 8);
    expectFrame(8'hF7, 2'b00, 1'b0);
    drive(2'b01, 7'h71, 8);
    drive(2'b11, 7'h00, 10);
    check("hold_data_out", {24'd0, bus.data_out}, 32'h0000_00F7);
    check("hold_valid", {31'd0, bus.data_valid}, 32'd0);

    repeat (20) @(negedge clk);
    check("pending_frames", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
